// File: rtl/led_fade_pkg.sv
// Shared types and the saturating level-step helper for the LED PWM fader.
// Used by led_pwm_channel and led_pwm_fader.
package led_fade_pkg;

    localparam int PWM_BITS_DEF = 8;

    // Widest brightness resolution the step helper supports.
    localparam int LVL_W = 16;

    typedef logic [PWM_BITS_DEF-1:0] level_t;
    typedef logic [LVL_W-1:0]        wide_level_t;

    localparam level_t LVL_MAX = '1;

    typedef enum logic [1:0] {
        FADE_HOLD,
        FADE_UP,
        FADE_DOWN
    } fade_dir_t;

    // Up saturates at max_level using one extra carry bit; down floors at zero.
    function automatic wide_level_t sat_step(
        input wide_level_t level,
        input fade_dir_t   dir,
        input wide_level_t step,
        input wide_level_t max_level
    );
        logic [LVL_W:0] sum;
        sum = {1'b0, level} + {1'b0, step};
        case (dir)
            FADE_UP:   sat_step = (sum > {1'b0, max_level}) ? max_level : sum[LVL_W-1:0];
            FADE_DOWN: sat_step = (level < step) ? '0 : level - step;
            default:   sat_step = level;
        endcase
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness level register, saturating ramp, compare and output flop.
// Define LED_FADE_GAMMA_EN for a square-law brightness curve (level MAX stays fully on).
module led_pwm_channel
    import led_fade_pkg::*;
#(
    parameter int PWM_BITS  = 8,
    parameter int FADE_STEP = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                target_on,
    input  logic                fade_en,
    input  logic                update,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_out,
    output logic                mismatch
);

    localparam logic [PWM_BITS-1:0] MAX = '1;

    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS-1:0] next_level;
    logic [PWM_BITS-1:0] cmp_level;
    fade_dir_t           dir;

    assign target   = target_on ? MAX : '0;
    assign mismatch = (level != target);

    always_comb begin
        dir = FADE_HOLD;
        if (level < target) begin
            dir = FADE_UP;
        end else if (level > target) begin
            dir = FADE_DOWN;
        end
    end

    assign next_level = PWM_BITS'(sat_step(wide_level_t'(level), dir,
                                           wide_level_t'(FADE_STEP),
                                           wide_level_t'(MAX)));

`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_wide;
    logic [2*PWM_BITS-1:0] squared;

    assign level_wide = {{PWM_BITS{1'b0}}, level};
    assign squared    = level_wide * level_wide;
    assign cmp_level  = PWM_BITS'(squared >> PWM_BITS);
`else
    assign cmp_level = level;
`endif

    // Level moves only at update so duty never changes mid-period; snap mode overrides.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level   <= '0;
            led_out <= 1'b0;
        end else begin
            if (!fade_en) begin
                level <= target;
            end else if (update) begin
                level <= next_level;
            end
            led_out <= (level == MAX) || (cmp_level > pwm_cnt);
        end
    end

endmodule

// File: rtl/led_pwm_fader.sv
// PWM LED fader top: prescaler, PWM period and step counters, pattern register, busy flag.
// Optional LED_FADE_GAMMA_EN selects the square-law curve inside each channel.
module led_pwm_fader
    import led_fade_pkg::*;
#(
    parameter int NUM_CH       = 8,
    parameter int PWM_BITS     = 8,
    parameter int CLK_DIV      = 4,
    parameter int STEP_PERIODS = 16,
    parameter int FADE_STEP    = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] pattern_in,
    input  logic              fade_en,
    output logic [NUM_CH-1:0] led_out,
    output logic              busy,
    output logic              period_strobe
);

    localparam int DIV_W  = (CLK_DIV > 1)      ? $clog2(CLK_DIV)      : 1;
    localparam int STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_PERIODS - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;

    logic [NUM_CH-1:0]   pattern_q;
    logic [DIV_W-1:0]    div_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [STEP_W-1:0]   step_cnt;
    logic                tick;
    logic                wrap;
    logic                update;
    logic [NUM_CH-1:0]   mismatch;

    assign tick   = (div_cnt == DIV_LAST);
    assign wrap   = tick && (pwm_cnt == PWM_MAX);
    assign update = wrap && (step_cnt == STEP_LAST);

    // pwm_cnt wraps MAX->0 naturally since MAX is all ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q     <= '0;
            div_cnt       <= '0;
            pwm_cnt       <= '0;
            step_cnt      <= '0;
            period_strobe <= 1'b0;
            busy          <= 1'b0;
        end else begin
            pattern_q <= pattern_in;
            div_cnt   <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            if (wrap) begin
                step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
            end
            period_strobe <= wrap;
            busy          <= |mismatch;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_pwm_channel #(
            .PWM_BITS  (PWM_BITS),
            .FADE_STEP (FADE_STEP)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .target_on (pattern_q[i]),
            .fade_en   (fade_en),
            .update    (update),
            .pwm_cnt   (pwm_cnt),
            .led_out   (led_out[i]),
            .mismatch  (mismatch[i])
        );
    end

endmodule
